// File: rtl/or_gate_level_pkg.sv
// Shared definitions for or_gate_level: default parameter values and small
// elaboration-time helpers used to size the reduction tree and the hit counter.
package or_gate_level_pkg;

    localparam int unsigned OR_GATE_LEVEL_DEF_WIDTH = 1;
    localparam int unsigned OR_GATE_LEVEL_DEF_CNT_W = 8;

    // Saturation value of a w-bit hit counter (all ones).
    function automatic logic [63:0] hit_cnt_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Number of nodes on level l of the reduction tree over w leaves:
    // each level halves the previous one, rounding up (odd node passes through).
    function automatic int unsigned lvl_width(input int unsigned w, input int unsigned l);
        return (w + (32'd1 << l) - 32'd1) >> l;
    endfunction

endpackage

// File: rtl/or_gate_level_or2_cell.sv
// or2_cell: 2-input OR gate primitive wrapper, the only datapath element of
// or_gate_level.
//   a, b : inputs
//   y    : a OR b
module or2_cell (
    input  logic a,
    input  logic b,
    output logic y
);

    or u_or (y, a, b);

endmodule

// File: rtl/or_gate_level.sv
// or_gate_level: registered, gate-level 3-input bitwise OR with valid flag and
// registered any-bit-set flag. The datapath is built only from or2_cell
// instances; the top holds the generate loops, output registers and the
// optional hit counter.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (priority over in_valid)
//   y        : registered a | b | c, holds while in_valid is low
//   a, b, c  : operands
//   in_valid : operands valid this cycle
//   y_valid  : y was captured from a valid input on the last edge
//   y_any    : registered OR-reduction of the captured result
//   hit_cnt  : saturating count of valid nonzero results
//              (only when OR_GATE_LEVEL_HIT_CNT_EN is defined)
//
// Optional feature macro: OR_GATE_LEVEL_HIT_CNT_EN
module or_gate_level
    import or_gate_level_pkg::*;
#(
    parameter int unsigned WIDTH = OR_GATE_LEVEL_DEF_WIDTH,
    parameter int unsigned CNT_W = OR_GATE_LEVEL_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             in_valid,
    output logic             y_valid,
    output logic             y_any
`ifdef OR_GATE_LEVEL_HIT_CNT_EN
    ,
    output logic [CNT_W-1:0] hit_cnt
`endif
);

    localparam int unsigned Levels = $clog2(WIDTH);

    if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
        $error("or_gate_level: WIDTH and CNT_W must be at least 1");
    end

    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] r;
    logic             y_any_next;

    // Two gate levels per bit: t = a OR b, r = t OR c.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        or2_cell u_or_ab (
            .a (a[i]),
            .b (b[i]),
            .y (t[i])
        );
        or2_cell u_or_c (
            .a (t[i]),
            .b (c[i]),
            .y (r[i])
        );
    end

    // Balanced reduction tree. Each level lives in its own generate block so
    // every level is a separate net; an odd trailing node passes straight up.
    for (genvar l = 0; l <= Levels; l++) begin : g_lvl
        localparam int unsigned N = lvl_width(WIDTH, l);
        logic [N-1:0] v;

        if (l == 0) begin : g_leaf
            assign v = r;
        end else begin : g_node
            localparam int unsigned M = lvl_width(WIDTH, l - 1);
            for (genvar j = 0; j < M / 2; j++) begin : g_pair
                or2_cell u_or_red (
                    .a (g_lvl[l-1].v[2*j]),
                    .b (g_lvl[l-1].v[2*j+1]),
                    .y (v[j])
                );
            end
            if (M % 2 == 1) begin : g_odd
                assign v[N-1] = g_lvl[l-1].v[M-1];
            end
        end
    end

    assign y_any_next = g_lvl[Levels].v[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= '0;
            y_any   <= 1'b0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= in_valid;
            if (in_valid) begin
                y     <= r;
                y_any <= y_any_next;
            end
        end
    end

`ifdef OR_GATE_LEVEL_HIT_CNT_EN
    localparam logic [CNT_W-1:0] HitCntMax = CNT_W'(hit_cnt_max(CNT_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt <= '0;
        end else if (in_valid && y_any_next && (hit_cnt != HitCntMax)) begin
            hit_cnt <= hit_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_or_gate_level.sv
// Self-checking bench for or_gate_level: a 1-bit instance for the exhaustive
// truth-table sweep and an 8-bit instance for directed and random checks,
// plus a 4-bit/2-bit-counter instance when OR_GATE_LEVEL_HIT_CNT_EN is set.
module tb_or_gate_level;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // WIDTH = 1 instance
    logic a1, b1, c1, v1;
    logic y1, yv1, ya1;

    // WIDTH = 8 instance
    logic [7:0] a8, b8, c8;
    logic       v8;
    logic [7:0] y8;
    logic       yv8, ya8;

    int n_cmp = 0;
    int n_bad = 0;

    or_gate_level #(.WIDTH(1)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .y        (y1),
        .a        (a1),
        .b        (b1),
        .c        (c1),
        .in_valid (v1),
        .y_valid  (yv1),
        .y_any    (ya1)
`ifdef OR_GATE_LEVEL_HIT_CNT_EN
        ,
        .hit_cnt  ()
`endif
    );

    or_gate_level #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .y        (y8),
        .a        (a8),
        .b        (b8),
        .c        (c8),
        .in_valid (v8),
        .y_valid  (yv8),
        .y_any    (ya8)
`ifdef OR_GATE_LEVEL_HIT_CNT_EN
        ,
        .hit_cnt  ()
`endif
    );

`ifdef OR_GATE_LEVEL_HIT_CNT_EN
    logic [3:0] ac, bc, cc;
    logic       vc;
    logic [3:0] yc;
    logic       yvc, yac;
    logic [1:0] hc;

    or_gate_level #(.WIDTH(4), .CNT_W(2)) u_dutc (
        .clk      (clk),
        .rst      (rst),
        .y        (yc),
        .a        (ac),
        .b        (bc),
        .c        (cc),
        .in_valid (vc),
        .y_valid  (yvc),
        .y_any    (yac),
        .hit_cnt  (hc)
    );
`endif

    typedef struct {
        logic a;
        logic b;
        logic c;
        logic y;
    } vec1_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec1_t tbl [8];
        logic [7:0] exp_y;
        logic       exp_any;

        // Truth table: output 0 only for a=b=c=0.
        for (int k = 0; k < 8; k++) begin
            tbl[k].a = k[2];
            tbl[k].b = k[1];
            tbl[k].c = k[0];
            tbl[k].y = (k != 0);
        end

        // Reset with a valid all-ones operand on the same edge: reset wins.
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
        a8 = 8'hff; b8 = 8'h00; c8 = 8'h00; v8 = 1'b1;
`ifdef OR_GATE_LEVEL_HIT_CNT_EN
        ac = 4'h0; bc = 4'h0; cc = 4'h0; vc = 1'b0;
`endif
        tick();
        chk("rst_y8", 32'(y8), 32'h0);
        chk("rst_any8", 32'(ya8), 32'h0);
        chk("rst_valid8", 32'(yv8), 32'h0);
        chk("rst_y1", 32'(y1), 32'h0);
        chk("rst_valid1", 32'(yv1), 32'h0);
        rst = 1'b0;
        v8 = 1'b0;

        // Exhaustive 1-bit sweep, back-to-back.
        for (int k = 0; k < 8; k++) begin
            a1 = tbl[k].a; b1 = tbl[k].b; c1 = tbl[k].c; v1 = 1'b1;
            tick();
            chk($sformatf("sweep_y[%0d]", k), 32'(y1), 32'(tbl[k].y));
            chk($sformatf("sweep_any[%0d]", k), 32'(ya1), 32'(tbl[k].y));
            chk($sformatf("sweep_valid[%0d]", k), 32'(yv1), 32'h1);
        end
        v1 = 1'b0;

        // 8-bit directed: one bit from each operand.
        a8 = 8'h01; b8 = 8'h10; c8 = 8'h80; v8 = 1'b1;
        tick();
        chk("w8_y", 32'(y8), 32'h91);
        chk("w8_any", 32'(ya8), 32'h1);
        chk("w8_valid", 32'(yv8), 32'h1);
        a8 = 8'h00; b8 = 8'h00; c8 = 8'h00;
        tick();
        chk("w8_zero_y", 32'(y8), 32'h00);
        chk("w8_zero_any", 32'(ya8), 32'h0);

        // Hold: result stays while in_valid is low, operands ignored.
        a8 = 8'h01; b8 = 8'h10; c8 = 8'h80; v8 = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            v8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom);
            tick();
            chk($sformatf("hold_y[%0d]", k), 32'(y8), 32'h91);
            chk($sformatf("hold_any[%0d]", k), 32'(ya8), 32'h1);
            chk($sformatf("hold_valid[%0d]", k), 32'(yv8), 32'h0);
        end

        // Mid-stream reset discards the in-flight operand.
        rst = 1'b1; v8 = 1'b1; a8 = 8'hff; b8 = 8'h00; c8 = 8'h00;
        tick();
        chk("mid_rst_y", 32'(y8), 32'h0);
        chk("mid_rst_any", 32'(ya8), 32'h0);
        chk("mid_rst_valid", 32'(yv8), 32'h0);
        rst = 1'b0; a8 = 8'h05; b8 = 8'h00; c8 = 8'h40;
        tick();
        chk("post_rst_y", 32'(y8), 32'h45);
        chk("post_rst_valid", 32'(yv8), 32'h1);

        // Random traffic against a behavioural model of the captured result.
        exp_y = 8'h45;
        exp_any = 1'b1;
        for (int k = 0; k < 300; k++) begin
            v8 = ($urandom_range(3) != 0);
            a8 = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
            b8 = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
            c8 = ($urandom_range(1) == 0) ? 8'h00 : (8'h1 << $urandom_range(7));
            if (v8) begin
                exp_y = a8 | b8 | c8;
                exp_any = (exp_y != 8'h00);
            end
            tick();
            chk($sformatf("rnd_y[%0d]", k), 32'(y8), 32'(exp_y));
            chk($sformatf("rnd_any[%0d]", k), 32'(ya8), 32'(exp_any));
            chk($sformatf("rnd_valid[%0d]", k), 32'(yv8), 32'(v8));
        end
        v8 = 1'b0;

`ifdef OR_GATE_LEVEL_HIT_CNT_EN
        // Saturating 2-bit counter.
        rst = 1'b1;
        tick();
        chk("cnt_rst", 32'(hc), 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            vc = 1'b1;
            ac = 4'($urandom_range(15, 1)); bc = 4'($urandom); cc = 4'($urandom);
            tick();
            chk($sformatf("cnt_seq[%0d]", k), 32'(hc), (k < 3) ? 32'(k + 1) : 32'h3);
        end
        ac = 4'h0; bc = 4'h0; cc = 4'h0;
        tick();
        chk("cnt_zero_hold", 32'(hc), 32'h3);
        vc = 1'b0;
        rst = 1'b1;
        tick();
        chk("cnt_rst2", 32'(hc), 32'h0);
        rst = 1'b0;
        // Invalid nonzero operands must not count.
        ac = 4'hf;
        tick();
        chk("cnt_invalid", 32'(hc), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
